// File: rtl/gearbox_rr_arbiter_if.sv
// Stream bundle between N_SRC sources, the round-robin arbiter and the gearbox.
// master: arbiter side; slave: sources plus gearbox side.
interface gearbox_rr_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int NB    = 40
);
  localparam int IW = $clog2(N_SRC);

  logic [N_SRC*NB-1:0] in_tdata;
  logic [N_SRC-1:0]    in_tvalid;
  logic [N_SRC-1:0]    in_tready;
  logic [NB-1:0]       out_tdata;
  logic                out_tvalid;
  logic                out_tready;
  logic [IW-1:0]       out_tid;
  logic                busy;

  modport master (
    input  in_tdata,
    input  in_tvalid,
    input  out_tready,
    output in_tready,
    output out_tdata,
    output out_tvalid,
    output out_tid,
    output busy
  );

  modport slave (
    output in_tdata,
    output in_tvalid,
    output out_tready,
    input  in_tready,
    input  out_tdata,
    input  out_tvalid,
    input  out_tid,
    input  busy
  );
endinterface

// File: rtl/gearbox_rr_arbiter.sv
// Round-robin arbiter feeding a 2x upsizing gearbox in locked bursts,
// so each upsized word carries beats from a single source.
module gearbox_rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int n     = 5,
  parameter int BURST = 2
) (
  input  logic                aclk,
  input  logic                areset,
  gearbox_rr_arbiter_if.master bus
);
  localparam int NB = n * 8;
  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(BURST);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  g, g_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [CW-1:0]  beat_cnt, cnt_n;
  logic [IW-1:0]  g_inc;
  logic [N_SRC-1:0] req;
  logic [IW-1:0]  scan_start;
  logic           found;
  logic [IW-1:0]  win;
  logic           hs;

  logic [N_SRC-1:0] rdy;
  logic [NB-1:0]    dat;
  logic             vld;
  logic [IW-1:0]    tid;
  logic             bsy;

  assign g_inc = (g == IW'(N_SRC - 1)) ? '0 : g + IW'(1);

  // At burst end the owner's current beat is the one being consumed,
  // so it must not count as a fresh request.
  assign req = (state == LOCK)
             ? (bus.in_tvalid & ~(N_SRC'(1) << g))
             : bus.in_tvalid;

  assign scan_start = (state == LOCK) ? g_inc : ptr;

  // Rotating priority scan: first requester at or after scan_start.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int j;
      j = (int'(scan_start) + k) % N_SRC;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  // Next-state logic and the combinational pass-through of the owner.
  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    cnt_n   = beat_cnt;
    rdy     = '0;
    dat     = '0;
    vld     = 1'b0;
    tid     = '0;
    bsy     = 1'b0;
    hs      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          g_n     = win;
          cnt_n   = '0;
          state_n = LOCK;
        end
      end
      LOCK: begin
        dat    = bus.in_tdata[g*NB +: NB];
        vld    = bus.in_tvalid[g];
        rdy[g] = bus.out_tready;
        tid    = g;
        bsy    = 1'b1;
        hs     = vld && bus.out_tready;
        if (hs) begin
          if (beat_cnt == CW'(BURST - 1)) begin
            ptr_n = g_inc;
            cnt_n = '0;
            if (found) begin
              g_n = win;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = beat_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State registers; reset abandons any partial burst.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      g        <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      g        <= g_n;
      ptr      <= ptr_n;
      beat_cnt <= cnt_n;
    end
  end

  assign bus.in_tready  = rdy;
  assign bus.out_tdata  = dat;
  assign bus.out_tvalid = vld;
  assign bus.out_tid    = tid;
  assign bus.busy       = bsy;

endmodule

// File: tb/tb_gearbox_rr_arbiter.sv
// Scoreboard bench for gearbox_rr_arbiter: random sources checked against
// a rule-level arbitration model plus directed burst/stall/reset scenarios.
module tb_gearbox_rr_arbiter;
  localparam int N     = 4;
  localparam int NB    = 40;
  localparam int BURST = 2;
  localparam int IW    = 2;

  logic aclk   = 1'b0;
  logic areset = 1'b1;

  gearbox_rr_arbiter_if #(.N_SRC(N), .NB(NB)) bus ();

  gearbox_rr_arbiter #(
    .N_SRC(N),
    .n(5),
    .BURST(BURST)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic          valid;
    logic [N-1:0]  rdy;
    logic          busy;
    logic [IW-1:0] tid;
    logic [NB-1:0] data;
  } rec_t;

  rec_t          exp_q[$];
  logic [NB-1:0] src_q[N][$];
  logic [N-1:0]  vld;
  logic [N-1:0]  took;
  logic [N-1:0]  want;
  logic [NB-1:0] dat[N];
  int            seq[N];
  int            p_valid;
  int            p_ready;
  int            stall;
  int            cyc;
  int            n_vec;
  int            n_err;
  int            tid_log[$];
  int            cyc_log[$];
  int            owner;
  int            left;
  int            ptr_m;
  int            pair_cnt;
  logic [IW-1:0] pair_tid;

  assign bus.in_tdata  = {dat[3], dat[2], dat[1], dat[0]};
  assign bus.in_tvalid = vld;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j[IW-1:0]]) return j;
    end
    return -1;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  // Sources: hold each beat until taken, then maybe offer the next one.
  always @(posedge aclk) begin
    #1;
    for (int s = 0; s < N; s++) begin
      if (took[s]) vld[s] = 1'b0;
      if (!vld[s] && want[s] && ($urandom_range(99) < p_valid)) begin
        seq[s]++;
        dat[s] = {8'(s), 32'(seq[s])};
        vld[s] = 1'b1;
        src_q[s].push_back(dat[s]);
      end
    end
    took = '0;
    if (stall > 0) begin
      bus.out_tready = 1'b0;
      stall--;
    end else begin
      bus.out_tready = ($urandom_range(99) < p_ready);
    end
  end

  // Reference model: owner / beats-left bookkeeping from the arbitration rules.
  always @(negedge aclk) begin
    rec_t r;
    int   nx;
    if (areset) begin
      owner = -1;
      ptr_m = 0;
    end
    r.valid = 1'b0;
    r.rdy   = '0;
    r.busy  = 1'b0;
    r.tid   = '0;
    r.data  = '0;
    if (owner >= 0) begin
      r.busy       = 1'b1;
      r.tid        = IW'(owner);
      r.valid      = vld[owner];
      r.rdy[owner] = bus.out_tready;
      if (vld[owner])
        r.data = (src_q[owner].size() > 0) ? src_q[owner][0] : '1;
    end
    exp_q.push_back(r);
    if (!areset) begin
      if (owner < 0) begin
        nx = first_from(vld, ptr_m);
        if (nx >= 0) begin
          owner = nx;
          left  = BURST;
        end
      end else if (vld[owner] && bus.out_tready) begin
        if (src_q[owner].size() > 0) void'(src_q[owner].pop_front());
        left--;
        if (left == 0) begin
          ptr_m = (owner + 1) % N;
          nx    = first_from(vld & ~(N'(1) << owner), ptr_m);
          if (nx >= 0) begin
            owner = nx;
            left  = BURST;
          end else begin
            owner = -1;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs with the model's prediction each cycle.
  always @(negedge aclk) begin
    rec_t r;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      r = exp_q.pop_front();
      chk("out_tvalid", 64'(bus.out_tvalid), 64'(r.valid));
      chk("in_tready", 64'(bus.in_tready), 64'(r.rdy));
      chk("busy", 64'(bus.busy), 64'(r.busy));
      if (r.busy) chk("out_tid", 64'(bus.out_tid), 64'(r.tid));
      if (r.valid) chk("out_tdata", 64'(bus.out_tdata), 64'(r.data));
    end
    took = bus.in_tready & vld;
    if (areset) begin
      pair_cnt = 0;
    end else if (bus.out_tvalid && bus.out_tready) begin
      tid_log.push_back(int'(bus.out_tid));
      cyc_log.push_back(cyc);
      if (pair_cnt % 2 == 1)
        chk("word_pair_tid", 64'(bus.out_tid), 64'(pair_tid));
      pair_tid = bus.out_tid;
      pair_cnt++;
    end
  end

  task automatic wait_hs(input int cnt, input int budget, input string name);
    int k;
    k = 0;
    while (tid_log.size() < cnt && k < budget) begin
      @(negedge aclk);
      #2;
      k++;
    end
    chk(name, 64'(tid_log.size() >= cnt), 64'd1);
  endtask

  task automatic reset_clear();
    @(posedge aclk);
    #2;
    areset = 1'b1;
    want   = '0;
    vld    = '0;
    took   = '0;
    stall  = 0;
    p_valid = 100;
    p_ready = 100;
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      seq[s] = 0;
    end
    @(posedge aclk);
    #2;
    tid_log.delete();
    cyc_log.delete();
    areset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    int t2_exp[10];
    int t4_exp[6];
    int per_src[N];
    t2_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    t4_exp = '{2, 2, 3, 3, 1, 1};
    vld = '0; took = '0; want = '0;
    p_valid = 100; p_ready = 100; stall = 0;
    cyc = 0; n_vec = 0; n_err = 0;
    owner = -1; left = 0; ptr_m = 0; pair_cnt = 0; pair_tid = '0;
    bus.out_tready = 1'b0;
    for (int s = 0; s < N; s++) begin
      dat[s] = '0;
      seq[s] = 0;
    end

    #3;
    chk("rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(bus.in_tready), 64'd0);
    chk("rst_out_tdata", 64'(bus.out_tdata), 64'd0);
    chk("rst_out_tid", 64'(bus.out_tid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge aclk);
    #2;
    areset = 1'b0;

    // T1: lone source 0, two bursts separated by one idle cycle.
    @(posedge aclk);
    #2;
    c0 = cyc;
    want = 4'b0001;
    wait_hs(4, 30, "t1_wait");
    want = '0;
    if (tid_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t1_tid", 64'(tid_log[i]), 64'd0);
      chk("t1_latency", 64'(cyc_log[0]), 64'(c0 + 2));
      chk("t1_span", 64'(cyc_log[3] - cyc_log[0]), 64'd4);
    end

    // T2: all sources busy, back-to-back bursts in rotation.
    reset_clear();
    want = '1;
    wait_hs(10, 40, "t2_wait");
    want = '0;
    if (tid_log.size() >= 10) begin
      for (int i = 0; i < 10; i++)
        chk("t2_tid_seq", 64'(tid_log[i]), 64'(t2_exp[i]));
      chk("t2_no_bubble", 64'(cyc_log[9] - cyc_log[0]), 64'd9);
    end

    // T3: sink stalls for 3 cycles after beat 1 of a source-1 burst.
    reset_clear();
    want = 4'b0010;
    wait_hs(1, 20, "t3_wait1");
    stall = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #2;
      chk("t3_in_tready", 64'(bus.in_tready), 64'd0);
      chk("t3_out_tid", 64'(bus.out_tid), 64'd1);
      chk("t3_out_tdata", 64'(bus.out_tdata), {24'd0, 8'h01, 32'd2});
    end
    wait_hs(2, 20, "t3_wait2");
    want = '0;
    if (tid_log.size() >= 2) begin
      chk("t3_tid", 64'(tid_log[1]), 64'd1);
      chk("t3_stall_gap", 64'(cyc_log[1] - cyc_log[0]), 64'd4);
    end

    // T4: requests raised mid-burst wait for the burst end.
    reset_clear();
    want = 4'b0100;
    wait_hs(1, 20, "t4_wait1");
    want = 4'b1110;
    wait_hs(6, 30, "t4_wait2");
    want = '0;
    if (tid_log.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        chk("t4_tid_seq", 64'(tid_log[i]), 64'(t4_exp[i]));
    end

    // T5: asynchronous reset in the middle of a source-3 burst.
    reset_clear();
    want = 4'b1000;
    wait_hs(1, 20, "t5_wait1");
    @(posedge aclk);
    #2;
    chk("t5_pre_busy", 64'(bus.busy), 64'd1);
    want = 4'b1010;
    areset = 1'b1;
    #1;
    chk("t5_out_tvalid", 64'(bus.out_tvalid), 64'd0);
    chk("t5_in_tready", 64'(bus.in_tready), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    @(posedge aclk);
    #2;
    tid_log.delete();
    cyc_log.delete();
    areset = 1'b0;
    wait_hs(1, 20, "t5_wait2");
    want = '0;
    if (tid_log.size() >= 1) chk("t5_first_grant", 64'(tid_log[0]), 64'd1);

    // T6: random valid/ready traffic against the model.
    reset_clear();
    p_valid = 60;
    p_ready = 70;
    want = '1;
    repeat (1000) @(posedge aclk);
    #2;
    want = '0;
    for (int s = 0; s < N; s++) per_src[s] = 0;
    foreach (tid_log[i]) per_src[tid_log[i]]++;
    chk("t6_progress", 64'(tid_log.size() >= 300), 64'd1);
    for (int s = 0; s < N; s++)
      chk("t6_fair_share", 64'(per_src[s] >= 50), 64'd1);
    repeat (5) @(posedge aclk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
